// File: rtl/vga_fb_pkg.sv
// rtl/vga_fb_pkg.sv - shared framebuffer arbitration types and defaults
// Holds the memory-op encoding and the default geometry used by fb_arbiter
// and fb_write_fifo. BYTE_BITS is the common pixel/byte width macro.
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

package vga_fb_pkg;

  // 320x240 bytes = 76800, needs 17 address bits
  localparam int FB_ADDR_BITS     = 17;
  localparam int FB_WR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } fb_op_e;

endpackage

// File: rtl/fb_write_fifo.sv
// rtl/fb_write_fifo.sv - plotter write buffer (address + data entries)
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   push, push_addr/data   enqueue one entry (ignored when full)
//   pop                    dequeue head entry (ignored when empty)
//   head_addr/head_data    current head entry
//   full, empty            occupancy flags from the current count
//   ready                  registered "not full"; low during reset
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module fb_write_fifo
  import vga_fb_pkg::*;
#(
  parameter int ADDR_BITS = FB_ADDR_BITS,
  parameter int DEPTH     = FB_WR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [ADDR_BITS-1:0]   push_addr,
  input  logic [`BYTE_BITS-1:0]  push_data,
  input  logic                   pop,
  output logic [ADDR_BITS-1:0]   head_addr,
  output logic [`BYTE_BITS-1:0]  head_data,
  output logic                   full,
  output logic                   empty,
  output logic                   ready
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_BITS-1:0]  addr_mem [DEPTH];
  logic [`BYTE_BITS-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic [PW:0]           count_next;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Push and pop together cancel out in the count
  assign count_next = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

  // Storage needs no reset: the pointers/count define what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // Follows the post-update count, so a pop only raises ready next cycle
      ready <= (count_next != (PW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer arbiter, display reads over plotter writes
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   rd_req, rd_addr              display fetch, one byte per asserted cycle
//   rd_valid, rd_data            fetched byte, 3 cycles after rd_req
//   wr_valid, wr_addr, wr_data   plotter write offer
//   wr_ready                     write buffer can accept
//   mem_en/we/addr/wdata         registered memory port strobe
//   mem_rdata                    memory data, one cycle after a read strobe
//   idle                         buffer empty and no read in flight
//   wr_stall_cnt                 cycles a buffered write lost to a read
// Build option: FB_ARB_STATS_EN enables the wr_stall_cnt counter (else 0).
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_BITS  = FB_ADDR_BITS,
  parameter int FIFO_DEPTH = FB_WR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_req,
  input  logic [ADDR_BITS-1:0]   rd_addr,
  output logic                   rd_valid,
  output logic [`BYTE_BITS-1:0]  rd_data,
  input  logic                   wr_valid,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [`BYTE_BITS-1:0]  wr_data,
  output logic                   wr_ready,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [`BYTE_BITS-1:0]  mem_wdata,
  input  logic [`BYTE_BITS-1:0]  mem_rdata,
  output logic                   idle,
  output logic [15:0]            wr_stall_cnt
);

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_ready;
  logic [ADDR_BITS-1:0]  head_addr;
  logic [`BYTE_BITS-1:0] head_data;
  logic                  push;
  logic                  pop;
  fb_op_e                op_q;
  // Set in the cycle the memory drives data for an earlier read strobe
  logic                  rd_data_stage;

  assign push     = wr_valid && fifo_ready && !fifo_full;
  assign pop      = !rd_req && !fifo_empty;
  assign wr_ready = fifo_ready;

  fb_write_fifo #(
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  // Decision and memory strobe share one register stage; the read
  // pipeline follows it so rd_valid lands exactly three cycles after rd_req.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q          <= OP_NONE;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      rd_data_stage <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
    end else begin
      if (rd_req) begin
        op_q     <= OP_READ;
        mem_addr <= rd_addr;
      end else if (!fifo_empty) begin
        op_q      <= OP_WRITE;
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end else begin
        op_q <= OP_NONE;
      end
      rd_data_stage <= (op_q == OP_READ);
      rd_valid      <= rd_data_stage;
      if (rd_data_stage) rd_data <= mem_rdata;
    end
  end

  assign mem_en = (op_q != OP_NONE);
  assign mem_we = (op_q == OP_WRITE);
  assign idle   = fifo_empty && (op_q != OP_READ) && !rd_data_stage && !rd_valid;

`ifdef FB_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (rd_req && !fifo_empty && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign wr_stall_cnt = stall_q;
`else
  assign wr_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter
`timescale 1ns/1ps

module tb_fb_arbiter;

  localparam int AW    = 17;
  localparam int DEPTH = 4;

  logic          clk      = 1'b0;
  logic          reset_n  = 1'b0;
  logic          rd_req   = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [7:0]    wr_data  = '0;
  logic [7:0]    mem_rdata;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          wr_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          idle;
  logic [15:0]   wr_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_BITS(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .idle         (idle),
    .wr_stall_cnt (wr_stall_cnt)
  );

  // Memory device: read data appears the cycle after the strobe
  bit [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
  end

  // Transaction-level model: a queue of accepted writes, a list of
  // reads with their due cycle, and a shadow of memory contents.
  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_ent_t;
  typedef struct { int due; logic [7:0] data; } rd_exp_t;

  wr_ent_t       wq[$];
  rd_exp_t       rq[$];
  bit [7:0]      mm [0:(1<<AW)-1];
  int            cyc = 0;
  bit            pend_w = 0;
  wr_ent_t       pend_ent;
  bit            m_acc;
  logic          e_en = 0, e_we = 0, e_rd_valid = 0, e_wr_ready = 0, e_idle = 1;
  logic [AW-1:0] e_addr = '0;
  logic [7:0]    e_wdata = '0, e_rd_data = '0;
  int            e_stall = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      wq.delete();
      rq.delete();
      pend_w     = 0;
      e_en       = 0;
      e_we       = 0;
      e_rd_valid = 0;
      e_wr_ready = 0;
      e_idle     = 1;
      e_stall    = 0;
    end else begin
      cyc++;
      if (pend_w) mm[pend_ent.addr] = pend_ent.data;
      pend_w = 0;
`ifdef FB_ARB_STATS_EN
      if (rd_req && wq.size() > 0 && e_stall < 65535) e_stall++;
`endif
      m_acc = wr_valid && e_wr_ready;
      if (rd_req) begin
        e_en = 1; e_we = 0; e_addr = rd_addr;
        rq.push_back('{due: cyc + 2, data: mm[rd_addr]});
      end else if (wq.size() > 0) begin
        pend_ent = wq.pop_front();
        pend_w   = 1;
        e_en = 1; e_we = 1; e_addr = pend_ent.addr; e_wdata = pend_ent.data;
      end else begin
        e_en = 0; e_we = 0;
      end
      if (m_acc) wq.push_back('{addr: wr_addr, data: wr_data});
      e_rd_valid = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_rd_valid = 1;
        e_rd_data  = rq[0].data;
        void'(rq.pop_front());
      end
      e_wr_ready = (wq.size() < DEPTH);
      e_idle     = (wq.size() == 0) && (rq.size() == 0) && !e_rd_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_mem_en"},   32'(mem_en), 32'd0);
    chk({tag, "_mem_we"},   32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"},32'(mem_wdata), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"},  32'(rd_data), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_idle"},     32'(idle), 32'd1);
    chk({tag, "_stall"},    32'(wr_stall_cnt), 32'd0);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset_n) begin
      reset_vals("rst");
    end else begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      if (e_en) begin
        chk("mem_we",   32'(mem_we), 32'(e_we));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
      chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
      if (e_rd_valid) chk("rd_data", 32'(rd_data), 32'(e_rd_data));
      chk("wr_ready", 32'(wr_ready), 32'(e_wr_ready));
      chk("idle",     32'(idle), 32'(e_idle));
      chk("stall",    32'(wr_stall_cnt), 32'(e_stall));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic v, input logic [AW-1:0] a, input logic [7:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    int exp_stall;
    repeat (3) tick();
    #2 reset_n = 1'b1;
    tick();
    chk("wr_ready_rise", 32'(wr_ready), 32'd1);
    chk("idle_after_reset", 32'(idle), 32'd1);

    // Single write lands two cycles after acceptance
    wr(1, 17'h00100, 8'h3C);
    tick();
    wr(0, '0, '0);
    tick();
    chk("w1_en",    32'(mem_en), 32'd1);
    chk("w1_we",    32'(mem_we), 32'd1);
    chk("w1_addr",  32'(mem_addr), 32'h00100);
    chk("w1_wdata", 32'(mem_wdata), 32'h3C);
    tick();
    chk("w1_idle",  32'(idle), 32'd1);
    chk("w1_done",  32'(mem_en), 32'd0);

    // Seed a location, then a single read returns it at N+3 only
    wr(1, 17'h12C00, 8'h2A);
    tick();
    wr(0, '0, '0);
    repeat (3) tick();
    rd_req  = 1'b1;
    rd_addr = 17'h12C00;
    tick();
    rd_req = 1'b0;
    chk("r1_n1", 32'(rd_valid), 32'd0);
    tick();
    chk("r1_n2", 32'(rd_valid), 32'd0);
    tick();
    chk("r1_n3_valid", 32'(rd_valid), 32'd1);
    chk("r1_n3_data",  32'(rd_data), 32'h2A);
    tick();
    chk("r1_n4", 32'(rd_valid), 32'd0);

    // Starvation: 4 buffered writes held off by 10 read cycles
    wr(1, 17'h01000, 8'h11);
    tick();
    rd_req  = 1'b1;
    rd_addr = 17'h00100;
    for (int k = 1; k < 4; k++) begin
      wr(1, 17'h01000 + AW'(k), 8'h11 + 8'(k));
      tick();
    end
    wr(0, '0, '0);
    chk("starve_full", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 7; i++) begin
      chk("starve_no_wr", 32'(mem_en && mem_we), 32'd0);
      tick();
    end
    rd_req = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      chk("drain_we",    32'(mem_en && mem_we), 32'd1);
      chk("drain_addr",  32'(mem_addr), 32'h01000 + 32'(j));
      chk("drain_wdata", 32'(mem_wdata), 32'h11 + 32'(j));
      tick();
    end
`ifdef FB_ARB_STATS_EN
    exp_stall = 10;
`else
    exp_stall = 0;
`endif
    chk("stall_cnt", 32'(wr_stall_cnt), 32'(exp_stall));
    chk("starve_idle", 32'(idle), 32'd1);

    // Full boundary: 5th offered in the cycle of the first pop
    rd_req  = 1'b1;
    rd_addr = 17'h00100;
    for (int k = 0; k < 4; k++) begin
      wr(1, 17'h02000 + AW'(k), 8'h21 + 8'(k));
      tick();
    end
    rd_req = 1'b0;
    wr(1, 17'h02004, 8'h25);
    chk("full_ready0", 32'(wr_ready), 32'd0);
    tick();
    chk("full_ready1", 32'(wr_ready), 32'd1);
    chk("full_pop0",   32'(mem_addr), 32'h02000);
    tick();
    wr(0, '0, '0);
    chk("full_ready2", 32'(wr_ready), 32'd1);
    for (int j = 1; j < 5; j++) begin
      chk("full_order", 32'(mem_addr), 32'h02000 + 32'(j));
      tick();
    end
    chk("full_no_extra", 32'(mem_en), 32'd0);

    // Reset with 3 writes buffered and reads in flight
    rd_req  = 1'b1;
    rd_addr = 17'h12C00;
    for (int k = 0; k < 3; k++) begin
      wr(1, 17'h03000 + AW'(k), 8'h31 + 8'(k));
      tick();
    end
    wr(0, '0, '0);
    repeat (2) tick();
    rd_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 reset_vals("async");
    repeat (2) tick();
    #2 reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("post_rst_no_strobe", 32'(mem_en), 32'd0);
      tick();
    end
    chk("post_rst_idle", 32'(idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
